// File: rtl/vdec_hs_pkg.sv
// Shared types and helpers for the HS-SCCH candidate sequencer.
// Holds the FSM encoding, SER width and the candidate search helpers.
package vdec_hs_pkg;

    localparam int NUM_CAND = 4;
    localparam int CAND_W   = 2;
    localparam int SER_W    = 7;
    localparam int ADDR_W   = 10;

    localparam logic [SER_W-1:0] SER_MAX = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_JUDGE,
        S_DONE
    } state_t;

    // Returns {valid, idx} of the lowest enabled candidate above cur
    // (or at cur when incl is set).
    function automatic logic [CAND_W:0] next_cand(
        input logic [NUM_CAND-1:0] mask,
        input logic [CAND_W-1:0]   cur,
        input logic                incl
    );
        logic              v;
        logic [CAND_W-1:0] idx;
        v   = 1'b0;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur) || (incl && i == int'(cur)))) begin
                v   = 1'b1;
                idx = CAND_W'(i);
            end
        end
        return {v, idx};
    endfunction

    function automatic logic [ADDR_W-1:0] cand_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] stride,
        input logic [CAND_W-1:0] k
    );
        return base + stride * {{(ADDR_W-CAND_W){1'b0}}, k};
    endfunction

endpackage

// File: rtl/vdec_hs_scch_rank.sv
// Best/second-best SER update for one captured candidate result.
module vdec_hs_scch_rank
    import vdec_hs_pkg::*;
(
    input  logic [6:0] best,
    input  logic [6:0] second,
    input  logic [1:0] best_idx,
    input  logic [6:0] ser_acc,
    input  logic [1:0] k,
    output logic [6:0] best_nxt,
    output logic [6:0] second_nxt,
    output logic [1:0] best_idx_nxt
);

    // Strict compares so ties keep the earlier (lower) candidate.
    always_comb begin
        best_nxt     = best;
        second_nxt   = second;
        best_idx_nxt = best_idx;
        if (ser_acc < best) begin
            second_nxt   = best;
            best_nxt     = ser_acc;
            best_idx_nxt = k;
        end else if (ser_acc < second) begin
            second_nxt = ser_acc;
        end
    end

endmodule

// File: rtl/vdec_hs_scch.sv
// HS-SCCH candidate sequencer: runs SER per enabled candidate, ranks
// the results and issues the detection verdict.
module vdec_hs_scch_sel
    import vdec_hs_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [3:0] cand_mask,
    input  logic [9:0] sys_base,
    input  logic [9:0] sys_stride,
    input  logic [6:0] ser_thr,
    input  logic [6:0] margin_thr,
    output logic       ser_start,
    output logic [9:0] ser_base_sys,
    output logic [1:0] ser_cand_idx,
    input  logic       ser_done,
    input  logic [6:0] ser_acc,
    output logic       found,
    output logic [1:0] det_idx,
    output logic [6:0] det_ser,
    output logic       err
);

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [3:0] mask_r;
    logic [9:0] base_r;
    logic [9:0] stride_r;
    logic [6:0] thr_r;
    logic [6:0] margin_r;
    logic [6:0] best_r;
    logic [6:0] second_r;
    logic [1:0] best_idx_r;
    logic [1:0] k_r;
    logic [7:0] wdog;

    logic [2:0] first;
    logic [2:0] nxt;
    logic [6:0] best_nxt;
    logic [6:0] second_nxt;
    logic [1:0] best_idx_nxt;
    logic [6:0] gap;
    logic       judge;

    assign first = next_cand(cand_mask, 2'd0, 1'b1);
    assign nxt   = next_cand(mask_r, k_r, 1'b0);
    assign gap   = second_r - best_r;
    assign judge = (mask_r != 4'd0) && (best_r <= thr_r)
                   && (gap >= margin_r);
    assign busy  = (state != S_IDLE) || start;

    vdec_hs_scch_rank u_rank (
        .best         (best_r),
        .second       (second_r),
        .best_idx     (best_idx_r),
        .ser_acc      (ser_acc),
        .k            (k_r),
        .best_nxt     (best_nxt),
        .second_nxt   (second_nxt),
        .best_idx_nxt (best_idx_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mask_r       <= '0;
            base_r       <= '0;
            stride_r     <= '0;
            thr_r        <= '0;
            margin_r     <= '0;
            best_r       <= '0;
            second_r     <= '0;
            best_idx_r   <= '0;
            k_r          <= '0;
            wdog         <= '0;
            done         <= 1'b0;
            ser_start    <= 1'b0;
            ser_base_sys <= '0;
            ser_cand_idx <= '0;
            found        <= 1'b0;
            det_idx      <= '0;
            det_ser      <= '0;
            err          <= 1'b0;
        end else begin
            ser_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_r     <= cand_mask;
                        base_r     <= sys_base;
                        stride_r   <= sys_stride;
                        thr_r      <= ser_thr;
                        margin_r   <= margin_thr;
                        best_r     <= SER_MAX;
                        second_r   <= SER_MAX;
                        best_idx_r <= '0;
                        err        <= 1'b0;
                        found      <= 1'b0;
                        if (first[2]) begin
                            k_r          <= first[1:0];
                            ser_cand_idx <= first[1:0];
                            ser_base_sys <= cand_addr(sys_base, sys_stride,
                                                      first[1:0]);
                            ser_start    <= 1'b1;
                            state        <= S_LAUNCH;
                        end else begin
                            state <= S_JUDGE;
                        end
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ser_done) begin
                        best_r     <= best_nxt;
                        second_r   <= second_nxt;
                        best_idx_r <= best_idx_nxt;
                        if (nxt[2]) begin
                            k_r          <= nxt[1:0];
                            ser_cand_idx <= nxt[1:0];
                            ser_base_sys <= cand_addr(base_r, stride_r,
                                                      nxt[1:0]);
                            ser_start    <= 1'b1;
                            state        <= S_LAUNCH;
                        end else begin
                            state <= S_JUDGE;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        // SER counter never answered: abort without a verdict
                        err     <= 1'b1;
                        found   <= 1'b0;
                        det_idx <= best_idx_r;
                        det_ser <= best_r;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                S_JUDGE: begin
                    found   <= judge;
                    det_idx <= best_idx_r;
                    det_ser <= best_r;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdec_hs_scch_sel.sv
// Directed table-driven bench for vdec_hs_scch_sel with a simple SER model.
module tb_vdec_hs_scch_sel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] cand_mask = '0;
    logic [9:0] sys_base = '0;
    logic [9:0] sys_stride = '0;
    logic [6:0] ser_thr = '0;
    logic [6:0] margin_thr = '0;
    logic       ser_start;
    logic [9:0] ser_base_sys;
    logic [1:0] ser_cand_idx;
    logic       ser_done = 1'b0;
    logic [6:0] ser_acc = '0;
    logic       found;
    logic [1:0] det_idx;
    logic [6:0] det_ser;
    logic       err;

    vdec_hs_scch_sel dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .cand_mask    (cand_mask),
        .sys_base     (sys_base),
        .sys_stride   (sys_stride),
        .ser_thr      (ser_thr),
        .margin_thr   (margin_thr),
        .ser_start    (ser_start),
        .ser_base_sys (ser_base_sys),
        .ser_cand_idx (ser_cand_idx),
        .ser_done     (ser_done),
        .ser_acc      (ser_acc),
        .found        (found),
        .det_idx      (det_idx),
        .det_ser      (det_ser),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]      mask;
        logic [9:0]      base;
        logic [9:0]      stride;
        logic [6:0]      thr;
        logic [6:0]      margin;
        logic [3:0][6:0] ser;
        int              dly;
        logic            e_found;
        logic [1:0]      e_idx;
        logic [6:0]      e_ser;
        int              e_nl;
        logic [3:0][9:0] e_addr;
        logic [3:0][1:0] e_cidx;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_errors = 0;

    // SER counter model
    logic [3:0][6:0] ser_tab = '0;
    int   mdelay = 0;
    logic model_en = 1'b1;
    logic pend = 1'b0;
    int   cnt = 0;
    logic [1:0] pidx = '0;
    int   nlaunch = 0;
    int   launch_addr [8];
    int   launch_idx [8];
    int   first_launch_cyc = -1;
    int   last_done_cyc = -1;

    always begin
        @(posedge clk);
        #1;
        ser_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (ser_start) begin
            if (nlaunch < 8) begin
                launch_addr[nlaunch] = int'(ser_base_sys);
                launch_idx[nlaunch]  = int'(ser_cand_idx);
            end
            if (nlaunch == 0) first_launch_cyc = cyc;
            nlaunch = nlaunch + 1;
            pend = 1'b1;
            cnt  = mdelay;
            pidx = ser_cand_idx;
        end else if (pend) begin
            if (cnt == 0) begin
                if (model_en) begin
                    ser_done = 1'b1;
                    ser_acc  = ser_tab[pidx];
                    last_done_cyc = cyc;
                end
                pend = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ser_start"}, int'(ser_start), 0);
        check({tag, "_base"}, int'(ser_base_sys), 0);
        check({tag, "_cidx"}, int'(ser_cand_idx), 0);
        check({tag, "_found"}, int'(found), 0);
        check({tag, "_det_idx"}, int'(det_idx), 0);
        check({tag, "_det_ser"}, int'(det_ser), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic setup(input int i);
        cand_mask  = vecs[i].mask;
        sys_base   = vecs[i].base;
        sys_stride = vecs[i].stride;
        ser_thr    = vecs[i].thr;
        margin_thr = vecs[i].margin;
        ser_tab    = vecs[i].ser;
        mdelay     = vecs[i].dly;
        nlaunch    = 0;
        first_launch_cyc = -1;
        last_done_cyc    = -1;
    endtask

    task automatic run_vec(input int i);
        int start_cyc;
        int done_cyc;
        bit got;
        setup(i);
        start = 1'b1;
        start_cyc = cyc;
        #1;
        check($sformatf("v%0d_busy_accept", i), int'(busy), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check($sformatf("v%0d_found_clr", i), int'(found), 0);
        check($sformatf("v%0d_err_clr", i), int'(err), 0);
        got = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 2000; n++) begin
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
            tick();
        end
        check($sformatf("v%0d_done_seen", i), int'(got), 1);
        check($sformatf("v%0d_found", i), int'(found), int'(vecs[i].e_found));
        check($sformatf("v%0d_det_idx", i), int'(det_idx), int'(vecs[i].e_idx));
        check($sformatf("v%0d_det_ser", i), int'(det_ser), int'(vecs[i].e_ser));
        check($sformatf("v%0d_err", i), int'(err), 0);
        check($sformatf("v%0d_nlaunch", i), nlaunch, vecs[i].e_nl);
        for (int j = 0; j < vecs[i].e_nl && j < 4; j++) begin
            check($sformatf("v%0d_addr%0d", i, j), launch_addr[j],
                  int'(vecs[i].e_addr[j]));
            check($sformatf("v%0d_cidx%0d", i, j), launch_idx[j],
                  int'(vecs[i].e_cidx[j]));
        end
        if (vecs[i].e_nl > 0) begin
            check($sformatf("v%0d_first_launch", i), first_launch_cyc,
                  start_cyc + 1);
            check($sformatf("v%0d_done_lat", i), done_cyc, last_done_cyc + 2);
        end else begin
            check($sformatf("v%0d_done_lat", i), done_cyc, start_cyc + 2);
        end
        tick();
        check($sformatf("v%0d_done_pulse", i), int'(done), 0);
        check($sformatf("v%0d_idle", i), int'(busy), 0);
        check($sformatf("v%0d_found_hold", i), int'(found),
              int'(vecs[i].e_found));
    endtask

    initial begin
        int start_cyc;
        int done_cyc;
        bit got;

        vecs[0] = '{4'b1111, 10'd100, 10'd40, 7'd5, 7'd4,
                    {7'd9, 7'd15, 7'd3, 7'd20}, 0,
                    1'b1, 2'd1, 7'd3, 4,
                    {10'd220, 10'd180, 10'd140, 10'd100},
                    {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{4'b0101, 10'd200, 10'd7, 7'd8, 7'd0,
                    {7'd0, 7'd6, 7'd0, 7'd6}, 3,
                    1'b1, 2'd0, 7'd6, 2,
                    {10'd0, 10'd0, 10'd214, 10'd200},
                    {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[2] = '{4'b0010, 10'd0, 10'd50, 7'd12, 7'd3,
                    {7'd0, 7'd0, 7'd10, 7'd0}, 0,
                    1'b1, 2'd1, 7'd10, 1,
                    {10'd0, 10'd0, 10'd0, 10'd50},
                    {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[3] = '{4'b0010, 10'd0, 10'd50, 7'd9, 7'd3,
                    {7'd0, 7'd0, 7'd10, 7'd0}, 1,
                    1'b0, 2'd1, 7'd10, 1,
                    {10'd0, 10'd0, 10'd0, 10'd50},
                    {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[4] = '{4'b0000, 10'd5, 10'd5, 7'd127, 7'd0,
                    {7'd0, 7'd0, 7'd0, 7'd0}, 0,
                    1'b0, 2'd0, 7'd127, 0,
                    {10'd0, 10'd0, 10'd0, 10'd0},
                    {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[5] = '{4'b1111, 10'd3, 10'd1, 7'd20, 7'd3,
                    {7'd50, 7'd40, 7'd12, 7'd10}, 2,
                    1'b0, 2'd0, 7'd10, 4,
                    {10'd6, 10'd5, 10'd4, 10'd3},
                    {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[6] = '{4'b0011, 10'd1000, 10'd40, 7'd10, 7'd5,
                    {7'd0, 7'd0, 7'd30, 7'd4}, 0,
                    1'b1, 2'd0, 7'd4, 2,
                    {10'd0, 10'd0, 10'd16, 10'd1000},
                    {2'd0, 2'd0, 2'd1, 2'd0}};

        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Watchdog abort, with a start pulse during WAIT that must be ignored
        setup(2);
        cand_mask = 4'b0100;
        sys_base  = 10'd10;
        sys_stride = 10'd3;
        model_en  = 1'b0;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        cand_mask = 4'b0001;
        got = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 600; n++) begin
            start = (n == 50);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
            tick();
        end
        start = 1'b0;
        check("to_done_seen", int'(got), 1);
        check("to_err", int'(err), 1);
        check("to_found", int'(found), 0);
        check("to_nlaunch", nlaunch, 1);
        check("to_addr", launch_addr[0], 16);
        check("to_first_launch", first_launch_cyc, start_cyc + 1);
        check("to_done_lat", done_cyc, first_launch_cyc + 256);
        tick();
        check("to_done_pulse", int'(done), 0);
        check("to_err_hold", int'(err), 1);
        model_en = 1'b1;
        tick();

        // Reset in WAIT, then a fresh run with a wrapping address
        setup(6);
        mdelay = 20;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("rst_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rst_hold_done", int'(done), 0);
        end
        rst_n = 1'b1;
        tick();
        check("rst_post_done", int'(done), 0);
        check("rst_post_busy", int'(busy), 0);
        run_vec(6);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
